// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick helper for async_req_arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_REQ     = 32;

  // Index of the first set bit of req_vec[n-1:0], searching upward from ptr and wrapping.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req_vec, input int ptr, input int n);
    int idx;
    bit found;
    rr_pick = 0;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && req_vec[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/req_sync.sv
// Multi-stage reset-low synchronizer bank for asynchronous, level-held request lines.
module req_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sync_r [STAGES];

  // Shift chain: stage 0 captures the raw line, the last stage feeds arbitration.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_r[s] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= async_in;
      for (int s = 1; s < STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sync_out = sync_r[STAGES-1];

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin 4-phase arbiter for asynchronous requesters of one shared resource.
// Optional grant-hold timeout with lockout is enabled by defining ARB_TIMEOUT_EN.
module async_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         async_req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int                 IW      = $clog2(NUM_REQ);
  localparam logic [IW-1:0]      LAST_ID = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_LSB = NUM_REQ'(1'b1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("async_req_arbiter: unsupported parameter set");
  end

  logic [NUM_REQ-1:0] sreq_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [IW-1:0]      pick_s;
  logic [IW-1:0]      next_ptr_s;

  arb_state_t         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [IW-1:0]      grant_id_r;
  logic               busy_r;
  logic [IW-1:0]      rr_ptr_r;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT_CYC + 1);
  logic [HW-1:0]      hold_cnt_r;
  logic               hold_last_s;
  logic [NUM_REQ-1:0] lock_r;
  logic               timeout_err_r;
`endif

  req_sync #(
    .WIDTH  (NUM_REQ),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (async_req),
    .sync_out (sreq_s)
  );

  // Eligible set, round-robin winner and the pointer value after the current owner.
  always_comb begin
`ifdef ARB_TIMEOUT_EN
    elig_s      = sreq_s & ~lock_r;
    hold_last_s = (hold_cnt_r == HW'(TIMEOUT_CYC - 1));
`else
    elig_s      = sreq_s;
`endif
    pick_s = IW'(rr_pick(MAX_REQ'(elig_s), int'(rr_ptr_r), NUM_REQ));
    if (grant_id_r == LAST_ID) begin
      next_ptr_s = {IW{1'b0}};
    end else begin
      next_ptr_s = grant_id_r + IW'(1);
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      grant_r       <= {NUM_REQ{1'b0}};
      grant_id_r    <= {IW{1'b0}};
      busy_r        <= 1'b0;
      rr_ptr_r      <= {IW{1'b0}};
`ifdef ARB_TIMEOUT_EN
      hold_cnt_r    <= {HW{1'b0}};
      lock_r        <= {NUM_REQ{1'b0}};
      timeout_err_r <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err_r <= 1'b0;
      // A lock survives only while the locked requester keeps its request up.
      lock_r        <= lock_r & sreq_s;
`endif
      case (state_r)
        IDLE: begin
          if (|elig_s) begin
            grant_r    <= ONE_LSB << pick_s;
            grant_id_r <= pick_s;
            busy_r     <= 1'b1;
            state_r    <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r <= {HW{1'b0}};
`endif
          end else begin
            grant_r <= {NUM_REQ{1'b0}};
            busy_r  <= 1'b0;
          end
        end
        GRANT: begin
          if (!sreq_s[grant_id_r]) begin
            grant_r  <= {NUM_REQ{1'b0}};
            busy_r   <= 1'b0;
            rr_ptr_r <= next_ptr_s;
            state_r  <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_last_s) begin
            grant_r              <= {NUM_REQ{1'b0}};
            busy_r               <= 1'b0;
            rr_ptr_r             <= next_ptr_s;
            state_r              <= IDLE;
            timeout_err_r        <= 1'b1;
            lock_r[grant_id_r]   <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
`else
          else begin
            grant_r <= grant_r;
          end
`endif
        end
        default: begin
          grant_r <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_req_arbiter.sv
// Self-checking bench for async_req_arbiter: vector table, directed corner sequences, random vs. model.
module tb_async_req_arbiter;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] async_req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  async_req_arbiter #(
    .NUM_REQ     (N),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req   (async_req),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         wait_n;
    logic [3:0] g;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [13];

  // Reference model state: owner = -1 means nobody holds the resource.
  logic [3:0] m_hist [SS];
  int         m_owner, m_ptr, m_gid, m_hold;
  logic [3:0] m_lock;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic inv();
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("busy_eq_or_grant", 32'(busy), 32'(|grant));
`ifndef ARB_TIMEOUT_EN
    chk("terr_tied", 32'(timeout_err), 32'd0);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    inv();
  endtask

  task automatic wait_grant(input int lim, input string name);
    int n = 0;
    while (grant == 4'd0 && n < lim) begin
      tick();
      n++;
    end
    chk(name, 32'(grant != 4'd0), 32'd1);
  endtask

  task automatic wait_idle(input int lim, input string name);
    int n = 0;
    while (grant != 4'd0 && n < lim) begin
      tick();
      n++;
    end
    chk(name, 32'(grant == 4'd0), 32'd1);
  endtask

  task automatic do_reset();
    n_rst     = 1'b0;
    async_req = 4'd0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = 4'd0;
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_hold  = 0;
    m_lock  = 4'd0;
    m_err   = 1'b0;
  endtask

  // Advances the model across one rising edge with din being the line value sampled there.
  task automatic model_step(input logic [3:0] din);
    logic [3:0] s;
    logic [3:0] elig;
    int         c;
    s     = m_hist[SS-1];
    m_err = 1'b0;
    elig  = s;
`ifdef ARB_TIMEOUT_EN
    elig   = s & ~m_lock;
    m_lock = m_lock & s;
`endif
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (m_owner < 0 && elig[c]) begin
          m_owner = c;
          m_gid   = c;
          m_hold  = 0;
        end
      end
    end else if (!s[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_hold++;
      if (m_hold >= TO) begin
        m_err          = 1'b1;
        m_lock[m_owner] = 1'b1;
        m_ptr          = (m_owner + 1) % N;
        m_owner        = -1;
      end
`endif
    end
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = din;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] exp_g;
    int         cnt;
    bit         found;

    // Reset held with all requests up.
    n_rst     = 1'b0;
    async_req = 4'b1111;
    repeat (5) begin
      tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
    end
    async_req = 4'd0;
    n_rst     = 1'b1;

    // Vector table: apply req, wait edges, compare. rr_ptr starts at 0.
    tbl[0]  = '{4'b0100, 2, 4'b0000, 2'd0};
    tbl[1]  = '{4'b0100, 1, 4'b0100, 2'd2};
    tbl[2]  = '{4'b0000, 2, 4'b0100, 2'd2};
    tbl[3]  = '{4'b0000, 1, 4'b0000, 2'd0};
    tbl[4]  = '{4'b0001, 3, 4'b0001, 2'd0};
    tbl[5]  = '{4'b0000, 3, 4'b0000, 2'd0};
    tbl[6]  = '{4'b1000, 3, 4'b1000, 2'd3};
    tbl[7]  = '{4'b1001, 5, 4'b1000, 2'd3};
    tbl[8]  = '{4'b0001, 3, 4'b0000, 2'd0};
    tbl[9]  = '{4'b0001, 1, 4'b0001, 2'd0};
    tbl[10] = '{4'b0000, 3, 4'b0000, 2'd0};
    tbl[11] = '{4'b0110, 3, 4'b0010, 2'd1};
    tbl[12] = '{4'b0000, 3, 4'b0000, 2'd0};
    for (int v = 0; v < 13; v++) begin
      async_req = tbl[v].req;
      repeat (tbl[v].wait_n) tick();
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(tbl[v].g));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(|tbl[v].g));
      if (tbl[v].g != 4'd0) chk($sformatf("vec%0d_id", v), 32'(grant_id), 32'(tbl[v].id));
    end

    // Round-robin with all requests held: order 0,1,2,3,0 and a gap between owners.
    do_reset();
    async_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, "rr_wait");
      chk("rr_order", 32'(grant_id), 32'(k % N));
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % N)));
      repeat (5) tick();
      chk("rr_hold", 32'(grant), 32'(4'b0001 << (k % N)));
      async_req[k % N] = 1'b0;
      wait_idle(10, "rr_gap");
      async_req[k % N] = 1'b1;
    end

    // Starvation freedom: req0 keeps coming back, req3 must win within two grants.
    do_reset();
    async_req = 4'b0001;
    wait_grant(10, "starve_first");
    async_req = 4'b1001;
    repeat (3) tick();
    found = 1'b0;
    for (int g = 0; g < 2; g++) begin
      if (!found) begin
        repeat (2) tick();
        async_req[0] = 1'b0;
        wait_idle(10, "starve_rel");
        async_req[0] = 1'b1;
        wait_grant(10, "starve_next");
        if (grant_id == 2'd3) found = 1'b1;
      end
    end
    chk("starve_req3", 32'(found), 32'd1);

`ifdef ARB_TIMEOUT_EN
    // Forced revoke after TO grant cycles, lockout until req1 is dropped and re-raised.
    do_reset();
    async_req = 4'b0010;
    wait_grant(10, "to_wait");
    cnt = 0;
    while (grant != 4'd0 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_hold_cycles", 32'(cnt), 32'(TO));
    chk("to_err_pulse", 32'(timeout_err), 32'd1);
    tick();
    chk("to_err_single", 32'(timeout_err), 32'd0);
    found = 1'b0;
    repeat (20) begin
      tick();
      if (grant != 4'd0 || timeout_err) found = 1'b1;
    end
    chk("to_locked", 32'(found), 32'd0);
    async_req = 4'b0000;
    repeat (4) tick();
    async_req = 4'b0010;
    wait_grant(10, "to_regrant");
    chk("to_regrant_id", 32'(grant_id), 32'd1);
`endif

    // Asynchronous reset mid-grant, then restart from rr_ptr=0.
    do_reset();
    async_req = 4'b0100;
    wait_grant(10, "arst_wait");
    #2 n_rst = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    async_req = 4'b1010;
    n_rst     = 1'b1;
    wait_grant(10, "arst_restart");
    chk("arst_first_id", 32'(grant_id), 32'd1);
    chk("arst_first_grant", 32'(grant), 32'b0010);

    // Random request activity against the reference model.
    do_reset();
    model_reset();
    r = 4'd0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      async_req = r;
      model_step(r);
      tick();
      exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rnd_grant", 32'(grant), 32'(exp_g));
      chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
      chk("rnd_terr", 32'(timeout_err), 32'(m_err));
      if (m_owner >= 0) chk("rnd_id", 32'(grant_id), 32'(m_gid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
